pipe_seq: RTL and testbench
===========================

# pipe_seq

Pipeline sequencer for the 16-bit five-stage processor. It produces every pipeline-register write enable and flush for the IF, ID, EX, MEM and WB stages. It resolves load-use hazards, taken-branch flushes, multi-cycle data-memory handshakes and the HALT instruction. It sits beside the hazard controller, consumes decoded stage fields, and also tracks memory-wait timeouts, stall cycles and flushes.

## Interface
Parameters:
- HALT_OP, 3'b111, opcode in IFID[15:13] that halts fetch.
- MEM_TIMEOUT, 16, maximum consecutive cycles a memory request may wait for mem_ack (≥2).
- CNT_W, 16, width of the performance counters.

Ports:
- clock  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- ifid_inst  in  16  instruction in IF/ID; opcode [15:13], rs [12:10], rt [9:7].
- idex_memread  in  1  instruction in ID/EX is a load.
- idex_dst  in  3  destination register of the ID/EX instruction.
- ex_branch_taken  in  1  branch in EX resolved taken this cycle.
- exmem_memop  in  1  EX/MEM holds a load or store.
- mem_ack  in  1  data memory completes the access this cycle.
- mem_req  out  1  data-memory request.
- pc_write  out  1  PC load enable.
- ifid_write, idex_write, exmem_write  out  1 each  pipeline-register load enables.
- ifid_flush, idex_flush, memwb_flush  out  1 each  insert a bubble (NOP) into that register.
- halted  out  1  sequencer is in HALT.
- fault  out  1  sequencer is in FAULT.
- stall_cycles  out  CNT_W  saturating count of front-end stall cycles.
- flush_count  out  CNT_W  saturating count of taken-branch flushes.

## Operation
- FSM states are RUN, HALT and FAULT. The reset state is RUN.
- Internal signals:
  - mem_busy = exmem_memop & ~mem_ack & state≠FAULT.
  - load_use = idex_memread & idex_dst≠0 & (idex_dst==rs | idex_dst==rt). Register 0 is hardwired, so it never hazards.
  - halt_hit = ifid_inst[15:13]==HALT_OP.
- Defaults: all write enables = 1, all flushes = 0.
- Actions in RUN are evaluated in strict priority order; only the first true item applies:
  1. mem_busy: pc_write = ifid_write = idex_write = exmem_write = 0 and memwb_flush = 1. The whole pipeline freezes and a bubble enters WB.
  2. ex_branch_taken: ifid_flush = idex_flush = 1. pc_write stays 1 so the PC loads the branch target. flush_count increments.
  3. load_use: pc_write = ifid_write = 0 and idex_flush = 1. This inserts one bubble per cycle while the condition holds.
  4. halt_hit: pc_write = ifid_write = 0 and idex_flush = 1. Next state is HALT.
- Counting in RUN: stall_cycles increments in every cycle with pc_write==0 (cases 1, 3 and 4). Counters saturate at all-ones.
- HALT state:
  - Front end stays frozen: pc_write = ifid_write = 0, idex_flush = 1 every cycle.
  - EX, MEM and WB drain. The mem_busy rule still applies to exmem_write and memwb_flush.
  - ex_branch_taken is ignored.
  - HALT is exited only by reset. halted = 1. Counters hold.
- FAULT state:
  - All write enables = 0. mem_req = 0. Flushes = 0. fault = 1.
  - FAULT is exited only by reset.
- mem_req = exmem_memop & state≠FAULT. It is level-held until mem_ack. When mem_ack arrives in the same cycle as the request, the access is a zero-wait access and causes no stall.
- Wait counter (width clog2(MEM_TIMEOUT)+1):
  - Increments each cycle mem_busy = 1; clears to 0 when mem_busy = 0.
  - If mem_busy is still 1 when the count equals MEM_TIMEOUT−1, the next state is FAULT.
  - The timeout applies in both RUN and HALT.
- Reset cycle:
  - Outputs: pc_write = ifid_write = idex_write = exmem_write = 0; ifid_flush = idex_flush = memwb_flush = 1; mem_req = halted = fault = 0.
  - Next state is RUN; counters and wait counter clear to 0.
  - Reset overrides every state, including a reset asserted mid-wait.

## Timing
- Enables, flushes and mem_req are combinational from the current state and inputs, valid in the same cycle.
- State, wait counter and perf counters are registered and update at the rising edge.
- Load-use costs exactly 1 bubble; the cycle after the bubble, idex_memread = 0 and the condition clears.
- A taken branch costs 2 flushed slots, both in one cycle.
- A memory access acknowledged N cycles after its request is first asserted freezes the pipeline for N cycles.
- halted rises the cycle after halt_hit is accepted.
- fault rises the cycle after the MEM_TIMEOUT-th consecutive busy cycle.

## Test plan
- Reset: assert reset 2 cycles -> write enables = 0, all three flushes = 1, stall_cycles = flush_count = 0, halted = fault = 0.
- Load-use: ifid_inst = 16'h4500 (rs = 1, rt = 2), idex_memread = 1, idex_dst = 2 -> one cycle with pc_write = 0, ifid_write = 0, idex_flush = 1; stall_cycles goes from 0 to 1. Repeat with idex_dst = 0 -> no stall.
- Branch priority over load-use: the load-use stimulus above plus ex_branch_taken = 1 -> ifid_flush = idex_flush = 1, pc_write = 1, flush_count = 1, stall_cycles unchanged.
- Memory wait: exmem_memop = 1, mem_ack low for 3 cycles then high -> mem_req = 1 for all 4 cycles, 3 freeze cycles with memwb_flush = 1, stall_cycles = 3. A zero-wait ack produces 0 freeze cycles.
- Timeout: MEM_TIMEOUT = 4, exmem_memop = 1, mem_ack held 0 -> fault = 1 on the cycle after the 4th busy cycle; mem_req = 0 and all enables = 0 afterwards; reset returns the block to RUN.
- Halt: ifid_inst[15:13] = 3'b111 in RUN -> halted = 1 next cycle; pc_write stays 0 for 10 cycles; exmem_write still follows mem_busy; ex_branch_taken = 1 has no effect.

Source files
------------

// File: rtl/pipe_seq.sv
// pipe_seq: pipeline sequencer that drives every stage write enable and bubble flush of the 5-stage core.
// Latency: enables, flushes and mem_req are combinational in the same cycle; state and counters update on the rising edge.
// Backpressure: an unacknowledged memory op freezes the pipe; a request stuck for MEM_TIMEOUT cycles parks the block in FAULT.
module pipe_seq #(
  parameter logic [2:0] HALT_OP     = 3'b111,
  parameter int         MEM_TIMEOUT = 16,
  parameter int         CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [15:0]      ifid_inst,
  input  logic             idex_memread,
  input  logic [2:0]       idex_dst,
  input  logic             ex_branch_taken,
  input  logic             exmem_memop,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_HALT  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;

  logic [2:0] rs, rt;
  logic       mem_busy, load_use, halt_hit;
  logic       unused_inst_bits;

  assign rs               = ifid_inst[12:10];
  assign rt               = ifid_inst[9:7];
  assign unused_inst_bits = ^ifid_inst[6:0];

  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  assign mem_busy = exmem_memop & ~mem_ack & (state_q != S_FAULT);
  assign load_use = idex_memread & (idex_dst != 3'd0) & ((idex_dst == rs) | (idex_dst == rt));
  assign halt_hit = (ifid_inst[15:13] == HALT_OP);

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Next-state, counter updates and all pipeline controls for the current state and inputs.
  always_comb begin
    state_d     = state_q;
    wait_d      = '0;
    stall_d     = stall_q;
    flush_d     = flush_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    mem_req     = exmem_memop & (state_q != S_FAULT);
    halted      = (state_q == S_HALT);
    fault       = (state_q == S_FAULT);

    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
      mem_req     = 1'b0;
      halted      = 1'b0;
      fault       = 1'b0;
      state_d     = S_RUN;
      stall_d     = '0;
      flush_d     = '0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (mem_busy) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            memwb_flush = 1'b1;
          end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_d    = sat_inc(flush_q);
          end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
          end else if (halt_hit) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            state_d    = S_HALT;
          end
          if (!pc_write) stall_d = sat_inc(stall_q);
        end
        S_HALT: begin
          // Front end stays frozen; the back end keeps draining unless memory stalls.
          // ID/EX is held with EX/MEM so the instruction waiting in EX is not lost.
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
          if (mem_busy) begin
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            memwb_flush = 1'b1;
          end
        end
        default: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_write  = 1'b0;
          exmem_write = 1'b0;
          mem_req     = 1'b0;
          fault       = 1'b1;
          state_d     = S_FAULT;
        end
      endcase

      // Count consecutive busy cycles; the MEM_TIMEOUT-th one trips FAULT.
      if (mem_busy) begin
        wait_d = wait_q + WAIT_W'(1);
        if (wait_q == WAIT_LAST) state_d = S_FAULT;
      end
    end
  end

  // State, wait counter and performance counters, cleared by synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_RUN;
      wait_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

endmodule

// File: tb/tb_pipe_seq.sv
// tb_pipe_seq: directed vector bench for pipe_seq (MEM_TIMEOUT = 4).
// Inputs change on the falling edge; combinational outputs are sampled 1ns later,
// registered outputs 1ns after the rising edge.
module tb_pipe_seq;

  logic        clock;
  logic        reset;
  logic [15:0] ifid_inst;
  logic        idex_memread;
  logic [2:0]  idex_dst;
  logic        ex_branch_taken;
  logic        exmem_memop;
  logic        mem_ack;
  logic        mem_req, pc_write, ifid_write, idex_write, exmem_write;
  logic        ifid_flush, idex_flush, memwb_flush, halted, fault;
  logic [15:0] stall_cycles, flush_count;

  int checks = 0;
  int errors = 0;

  pipe_seq #(.HALT_OP(3'b111), .MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .clock          (clock),
    .reset          (reset),
    .ifid_inst      (ifid_inst),
    .idex_memread   (idex_memread),
    .idex_dst       (idex_dst),
    .ex_branch_taken(ex_branch_taken),
    .exmem_memop    (exmem_memop),
    .mem_ack        (mem_ack),
    .mem_req        (mem_req),
    .pc_write       (pc_write),
    .ifid_write     (ifid_write),
    .idex_write     (idex_write),
    .exmem_write    (exmem_write),
    .ifid_flush     (ifid_flush),
    .idex_flush     (idex_flush),
    .memwb_flush    (memwb_flush),
    .halted         (halted),
    .fault          (fault),
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Control bundle order:
  // {mem_req, pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush, memwb_flush, halted, fault}
  localparam logic [9:0] C_NORM  = 10'b0111100000;
  localparam logic [9:0] C_RESET = 10'b0000011100;
  localparam logic [9:0] C_FAULT = 10'b0000000001;

  typedef struct {
    logic [15:0] inst;
    logic        memread;
    logic [2:0]  dst;
    logic        br;
    logic        memop;
    logic        ack;
    logic [9:0]  ctl;
    logic [15:0] stall;
    logic [15:0] flushes;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [9:0] ctl_now();
    return {mem_req, pc_write, ifid_write, idex_write, exmem_write,
            ifid_flush, idex_flush, memwb_flush, halted, fault};
  endfunction

  function automatic vec_t mk(input logic [15:0] inst, input logic mr, input logic [2:0] dst,
                              input logic br, input logic mo, input logic ack,
                              input logic [9:0] ctl, input logic [15:0] st, input logic [15:0] fl);
    vec_t v;
    v.inst = inst; v.memread = mr; v.dst = dst; v.br = br; v.memop = mo; v.ack = ack;
    v.ctl = ctl; v.stall = st; v.flushes = fl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic [15:0] inst, input logic mr, input logic [2:0] dst,
                        input logic br, input logic mo, input logic ack);
    ifid_inst = inst; idex_memread = mr; idex_dst = dst;
    ex_branch_taken = br; exmem_memop = mo; mem_ack = ack;
    #1;
  endtask

  task automatic after_edge();
    @(posedge clock);
    #1;
  endtask

  int   exp_stall;
  int   freeze;
  logic busy;

  initial begin
    reset = 1'b1;
    set_in(16'h0000, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);

    // Reset held for two cycles, with a memory op pending to show mem_req is masked.
    chk("reset_ctl_0", 32'(ctl_now()), 32'(C_RESET));
    after_edge();
    @(negedge clock);
    chk("reset_ctl_1", 32'(ctl_now()), 32'(C_RESET));
    after_edge();
    chk("reset_stall", 32'(stall_cycles), 32'd0);
    chk("reset_flush", 32'(flush_count), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Single-cycle RUN vectors; counter columns are the values after that cycle's edge.
    vecs[0]  = mk(16'h0000, 0, 3'd0, 0, 0, 0, C_NORM,        16'd0, 16'd0); // idle
    vecs[1]  = mk(16'h4500, 1, 3'd2, 0, 0, 0, 10'b0001101000, 16'd1, 16'd0); // load-use on rt
    vecs[2]  = mk(16'h4500, 1, 3'd0, 0, 0, 0, C_NORM,        16'd1, 16'd0); // r0 never hazards
    vecs[3]  = mk(16'h4500, 1, 3'd1, 0, 0, 0, 10'b0001101000, 16'd2, 16'd0); // load-use on rs
    vecs[4]  = mk(16'h4500, 0, 3'd2, 0, 0, 0, C_NORM,        16'd2, 16'd0); // not a load
    vecs[5]  = mk(16'h4500, 1, 3'd2, 1, 0, 0, 10'b0111111000, 16'd2, 16'd1); // branch beats load-use
    vecs[6]  = mk(16'h0000, 0, 3'd0, 1, 0, 0, 10'b0111111000, 16'd2, 16'd2); // plain branch
    vecs[7]  = mk(16'h0000, 0, 3'd0, 0, 1, 1, 10'b1111100000, 16'd2, 16'd2); // zero-wait access
    vecs[8]  = mk(16'h0000, 0, 3'd0, 1, 1, 0, 10'b1000000100, 16'd3, 16'd2); // busy beats branch
    vecs[9]  = mk(16'h0000, 0, 3'd0, 0, 1, 1, 10'b1111100000, 16'd3, 16'd2); // ack
    vecs[10] = mk(16'h4500, 1, 3'd2, 0, 1, 0, 10'b1000000100, 16'd4, 16'd2); // busy beats load-use
    vecs[11] = mk(16'h4500, 1, 3'd2, 0, 1, 1, 10'b1001101000, 16'd5, 16'd2); // ack + load-use
    vecs[12] = mk(16'h0000, 0, 3'd0, 0, 0, 0, C_NORM,        16'd5, 16'd2); // idle

    for (int i = 0; i < 13; i++) begin
      set_in(vecs[i].inst, vecs[i].memread, vecs[i].dst, vecs[i].br, vecs[i].memop, vecs[i].ack);
      chk($sformatf("vec%0d_ctl", i), 32'(ctl_now()), 32'(vecs[i].ctl));
      after_edge();
      chk($sformatf("vec%0d_stall", i), 32'(stall_cycles), 32'(vecs[i].stall));
      chk($sformatf("vec%0d_flush", i), 32'(flush_count), 32'(vecs[i].flushes));
      @(negedge clock);
    end
    exp_stall = 5;

    // Memory wait: ack arrives on the 4th request cycle -> 3 frozen cycles.
    freeze = 0;
    for (int i = 0; i < 4; i++) begin
      set_in(16'h0000, 0, 3'd0, 0, 1, (i == 3));
      chk($sformatf("memwait_req%0d", i), 32'(mem_req), 32'd1);
      if (!pc_write && memwb_flush) freeze++;
      after_edge();
      @(negedge clock);
    end
    exp_stall += 3;
    chk("memwait_freeze", 32'(freeze), 32'd3);
    chk("memwait_stall", 32'(stall_cycles), 32'(exp_stall));

    // Zero-wait access: no freeze.
    freeze = 0;
    set_in(16'h0000, 0, 3'd0, 0, 1, 1);
    if (!pc_write && memwb_flush) freeze++;
    after_edge();
    @(negedge clock);
    chk("zerowait_freeze", 32'(freeze), 32'd0);

    // Timeout: four busy cycles, FAULT from the next cycle on.
    for (int i = 0; i < 4; i++) begin
      set_in(16'h0000, 0, 3'd0, 0, 1, 0);
      chk($sformatf("timeout_busy%0d", i), 32'(ctl_now()), 32'(10'b1000000100));
      after_edge();
      @(negedge clock);
    end
    exp_stall += 4;
    for (int i = 0; i < 2; i++) begin
      set_in(16'h0000, 0, 3'd0, 1, 1, 0);
      chk($sformatf("fault_ctl%0d", i), 32'(ctl_now()), 32'(C_FAULT));
      after_edge();
      chk($sformatf("fault_stall%0d", i), 32'(stall_cycles), 32'(exp_stall));
      chk($sformatf("fault_flush%0d", i), 32'(flush_count), 32'd2);
      @(negedge clock);
    end
    reset = 1'b1;
    set_in(16'h0000, 0, 3'd0, 0, 1, 0);
    chk("fault_reset_ctl", 32'(ctl_now()), 32'(C_RESET));
    after_edge();
    chk("fault_reset_stall", 32'(stall_cycles), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    set_in(16'h0000, 0, 3'd0, 0, 0, 0);
    chk("post_fault_run", 32'(ctl_now()), 32'(C_NORM));

    // Halt: accepted in RUN, halted the next cycle, front end frozen, back end drains.
    set_in(16'hE000, 0, 3'd0, 0, 0, 0);
    chk("halt_accept_ctl", 32'(ctl_now()), 32'(10'b0001101000));
    after_edge();
    chk("halt_rise", 32'(halted), 32'd1);
    chk("halt_stall", 32'(stall_cycles), 32'd1);
    @(negedge clock);
    for (int i = 0; i < 10; i++) begin
      busy = ((i % 3) != 2);
      set_in(16'h0000, 0, 3'd0, i[0], 1, ~busy);
      chk($sformatf("halt_cyc%0d", i),
          32'({mem_req, pc_write, ifid_write, ifid_flush, idex_flush, exmem_write, memwb_flush, halted, fault}),
          32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ~busy, busy, 1'b1, 1'b0}));
      after_edge();
      @(negedge clock);
    end
    chk("halt_stall_hold", 32'(stall_cycles), 32'd1);
    chk("halt_flush_hold", 32'(flush_count), 32'd0);

    reset = 1'b1;
    set_in(16'h0000, 0, 3'd0, 0, 0, 0);
    after_edge();
    chk("final_reset_halted", 32'(halted), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
